// File: rtl/signal_branch.sv
// signal_branch: registered branch-taken strobe decoded from InsM[15:8] and PSW Z/C.
// Optional macro SIGNAL_BRANCH_JUMP_EN: JMP/JALrl/JALrr/JR also force Branch=1.
module signal_branch (
  input  logic       clk,
  input  logic       Rst,
  input  logic [1:0] PSW_NZC,
  input  logic [7:0] InsM,
  output logic       Branch
);

  typedef enum logic [3:0] {
    COND_BNE = 4'b0000,
    COND_BEQ = 4'b0001,
    COND_BCS = 4'b0010,
    COND_BCC = 4'b0011,
    COND_BAL = 4'b1110
  } cond_e;

  localparam logic [3:0] OP_BRANCH = 4'b1100;
`ifdef SIGNAL_BRANCH_JUMP_EN
  // Jumps occupy 10000-10011, so only the top three opcode bits matter.
  localparam logic [2:0] OP_JUMP_HI = 3'b100;
`endif

  logic [3:0] opcode;
  logic [3:0] cond;
  logic       flag_z;
  logic       flag_c;
  logic       branch_d;
  logic       branch_q;

  assign opcode = InsM[7:4];
  assign cond   = InsM[3:0];
  assign flag_z = PSW_NZC[1];
  assign flag_c = PSW_NZC[0];

  // An unknown opcode makes the if-condition non-true, so branch_d keeps its 0 default.
  always_comb begin
    branch_d = 1'b0;
    if (opcode == OP_BRANCH) begin
      case (cond)
        COND_BNE: branch_d = ~flag_z;
        COND_BEQ: branch_d = flag_z;
        COND_BCS: branch_d = flag_c;
        COND_BCC: branch_d = ~flag_c;
        COND_BAL: branch_d = 1'b1;
        default:  branch_d = 1'b0;
      endcase
    end
`ifdef SIGNAL_BRANCH_JUMP_EN
    if (InsM[7:5] == OP_JUMP_HI) begin
      branch_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      branch_q <= 1'b0;
    end else begin
      branch_q <= branch_d;
    end
  end

  assign Branch = branch_q;

endmodule

// File: tb/tb_signal_branch.sv
// Self-checking bench for signal_branch: directed vector table, corner sequences,
// and randomized stimulus against a value-level reference model.
module tb_signal_branch;

  logic       clk;
  logic       Rst;
  logic [1:0] PSW_NZC;
  logic [7:0] InsM;
  logic       Branch;

  int tests;
  int failed;

`ifdef SIGNAL_BRANCH_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] insm;
    logic [1:0] flags;
    logic       exp;
  } vec_t;

  vec_t vecs[64];
  int   nvec;

  signal_branch dut (
    .clk    (clk),
    .Rst    (Rst),
    .PSW_NZC(PSW_NZC),
    .InsM   (InsM),
    .Branch (Branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the set of taken instructions written as explicit byte values.
  function automatic logic model_taken(input logic [7:0] insm, input logic [1:0] flags);
    logic z;
    logic c;
    z = flags[1];
    c = flags[0];
    return (insm == 8'hC0 && !z) || (insm == 8'hC1 && z) ||
           (insm == 8'hC2 && c)  || (insm == 8'hC3 && !c) ||
           (insm == 8'hCE) ||
           (JUMP_EN && insm >= 8'h80 && insm <= 8'h9F);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: Branch=%b expected %b", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [7:0] insm, input logic [1:0] flags, input logic exp);
    vecs[nvec].insm  = insm;
    vecs[nvec].flags = flags;
    vecs[nvec].exp   = exp;
    nvec++;
  endtask

  // Apply just after a rising edge, then sample 1 ns after the next one.
  task automatic apply_and_check(input string name, input logic [7:0] insm,
                                 input logic [1:0] flags, input logic exp);
    InsM    = insm;
    PSW_NZC = flags;
    @(posedge clk);
    #1;
    $display("[TB] %s InsM=%02h flags=%02b Branch=%b exp=%b", name, insm, flags, Branch, exp);
    check(name, Branch, exp);
  endtask

  logic [7:0] nb_list[11];
  logic [7:0] jmp_list[4];

  initial begin
    tests   = 0;
    failed  = 0;
    nvec    = 0;
    Rst     = 1'b0;
    InsM    = 8'hCE;
    PSW_NZC = 2'b00;

    nb_list  = '{8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h00, 8'h38, 8'h40, 8'h58, 8'hE0};
    jmp_list = '{8'h80, 8'h88, 8'h90, 8'h98};

    // Branch group, flags 00 then 11
    add_vec(8'hC0, 2'b00, 1'b1);
    add_vec(8'hC1, 2'b00, 1'b0);
    add_vec(8'hC2, 2'b00, 1'b0);
    add_vec(8'hC3, 2'b00, 1'b1);
    add_vec(8'hCE, 2'b00, 1'b1);
    add_vec(8'hC0, 2'b11, 1'b0);
    add_vec(8'hC1, 2'b11, 1'b1);
    add_vec(8'hC2, 2'b11, 1'b1);
    add_vec(8'hC3, 2'b11, 1'b0);
    add_vec(8'hCE, 2'b11, 1'b1);
    // Mixed flags and reserved condition codes
    add_vec(8'hC0, 2'b01, 1'b1);
    add_vec(8'hC1, 2'b10, 1'b1);
    add_vec(8'hC2, 2'b10, 1'b0);
    add_vec(8'hC3, 2'b10, 1'b1);
    add_vec(8'hC4, 2'b11, 1'b0);
    add_vec(8'hCF, 2'b00, 1'b0);
    add_vec(8'hCD, 2'b01, 1'b0);
    for (int i = 0; i < 11; i++) begin
      add_vec(nb_list[i], 2'b00, 1'b0);
      add_vec(nb_list[i], 2'b11, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      add_vec(jmp_list[i], 2'b00, JUMP_EN);
      add_vec(jmp_list[i], 2'b11, JUMP_EN);
    end

    // Reset held low for two cycles with BAL present
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      $display("[TB] reset_hold cycle=%0d Branch=%b exp=0", i, Branch);
      check("reset_hold", Branch, 1'b0);
    end
    @(negedge clk);
    Rst = 1'b1;
    #1;
    check("reset_release_no_edge", Branch, 1'b0);
    @(posedge clk);
    #1;
    $display("[TB] first_eval InsM=CE Branch=%b exp=1", Branch);
    check("first_eval", Branch, 1'b1);

    for (int i = 0; i < nvec; i++) begin
      apply_and_check($sformatf("vec%0d", i), vecs[i].insm, vecs[i].flags, vecs[i].exp);
    end

    // One-cycle latency: output still reflects the previous instruction before the edge
    apply_and_check("lat_setup", 8'hCE, 2'b00, 1'b1);
    InsM = 8'h00;
    #3;
    check("lat_no_comb_path", Branch, 1'b1);
    @(posedge clk);
    #1;
    check("lat_after_edge", Branch, 1'b0);

    // Steady BAL for several cycles stays high
    for (int i = 0; i < 4; i++) begin
      apply_and_check("bal_hold", 8'hCE, 2'(i), 1'b1);
    end

    // Asynchronous reset mid-cycle while Branch=1
    apply_and_check("async_setup", 8'hCE, 2'b00, 1'b1);
    #3;
    Rst = 1'b0;
    #1;
    $display("[TB] async_reset Branch=%b exp=0", Branch);
    check("async_reset", Branch, 1'b0);
    @(negedge clk);
    Rst = 1'b1;
    @(posedge clk);
    #1;
    check("async_recover", Branch, 1'b1);

    // Randomized stimulus, biased toward the branch group
    for (int i = 0; i < 300; i++) begin
      logic [7:0] r_insm;
      logic [1:0] r_flags;
      r_flags = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0, 1:    r_insm = {4'hC, 4'($urandom_range(0, 15))};
        2:       r_insm = {3'b100, 5'($urandom_range(0, 31))};
        default: r_insm = 8'($urandom_range(0, 255));
      endcase
      apply_and_check($sformatf("rand%0d", i), r_insm, r_flags, model_taken(r_insm, r_flags));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
